// File: rtl/rs_latch_ctrl.sv
// rs_latch_ctrl: debounced button front-end that drives the
// active-low s/r pins of a NAND RS latch without ever hitting s=r=0.
`timescale 1ns/1ps
module rs_latch_ctrl #(
  parameter int DEB_CYC = 4,
  parameter int PULSE_W = 3,
  parameter int GAP_W   = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_set,
  input  logic btn_rst,
  output logic s,
  output logic r,
  output logic busy,
  output logic q_exp,
  output logic conflict
);

  typedef enum logic [1:0] {
    IDLE,
    SET_P,
    RST_P,
    GAP
  } state_t;

  localparam logic [7:0] DEB_LIM = 8'(DEB_CYC - 1);
  localparam logic [3:0] PW      = 4'(PULSE_W);
  localparam logic [3:0] GW      = 4'(GAP_W);

  // Channel index 0 is set, 1 is reset.
  logic [1:0]      btn;
  logic [1:0]      sync1_q, sync2_q;
  logic [1:0]      deb_q, deb_d, debp_q;
  logic [1:0][7:0] cnt_q, cnt_d;
  logic [1:0]      rise, req, go, kept;
  logic [1:0]      pend_q, pend_d;
  logic            old_set_q, old_set_d;
  logic            both;
  state_t          state_q;
  logic [3:0]      wcnt_q;
  logic            s_q, r_q, busy_q, q_exp_q, conflict_q;

  assign btn = {btn_rst, btn_set};

  // Two-flop synchronizer per button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: level flips after DEB_CYC consecutive differing cycles.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DEB_LIM) begin
          deb_d[i] = ~deb_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end
    end
  end

  // Debounced level, its previous value and the run counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q  <= '0;
      debp_q <= '0;
      cnt_q  <= '0;
    end else begin
      deb_q  <= deb_d;
      debp_q <= deb_q;
      cnt_q  <= cnt_d;
    end
  end

  // Request capture, conflict filtering and arbitration by age.
  always_comb begin
    rise = deb_q & ~debp_q;
    both = &rise;
    req  = both ? 2'b00 : rise;
    go   = 2'b00;
    if (state_q == IDLE) begin
      go[0] = pend_q[0] & (~pend_q[1] | old_set_q);
      go[1] = pend_q[1] & (~pend_q[0] | ~old_set_q);
    end
    kept      = pend_q & ~go;
    pend_d    = (pend_q | req) & ~go;
    old_set_d = old_set_q;
    if (req[0] && !kept[1]) old_set_d = 1'b1;
    if (req[1] && !kept[0]) old_set_d = 1'b0;
  end

  // Pulse FSM with registered latch drives and status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wcnt_q     <= '0;
      pend_q     <= '0;
      old_set_q  <= 1'b0;
      s_q        <= 1'b1;
      r_q        <= 1'b1;
      busy_q     <= 1'b0;
      q_exp_q    <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      old_set_q  <= old_set_d;
      conflict_q <= both;
      unique case (state_q)
        IDLE: begin
          if (go[0]) begin
            state_q <= SET_P;
            wcnt_q  <= PW;
            s_q     <= 1'b0;
            busy_q  <= 1'b1;
          end else if (go[1]) begin
            state_q <= RST_P;
            wcnt_q  <= PW;
            r_q     <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        SET_P: begin
          if (wcnt_q == 4'd1) begin
            state_q <= GAP;
            wcnt_q  <= GW;
            s_q     <= 1'b1;
            q_exp_q <= 1'b1;
          end else begin
            wcnt_q <= wcnt_q - 4'd1;
          end
        end
        RST_P: begin
          if (wcnt_q == 4'd1) begin
            state_q <= GAP;
            wcnt_q  <= GW;
            r_q     <= 1'b1;
            q_exp_q <= 1'b0;
          end else begin
            wcnt_q <= wcnt_q - 4'd1;
          end
        end
        GAP: begin
          if (wcnt_q == 4'd1) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            wcnt_q <= wcnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s        = s_q;
  assign r        = r_q;
  assign busy     = busy_q;
  assign q_exp    = q_exp_q;
  assign conflict = conflict_q;

endmodule

// File: tb/tb_rs_latch_ctrl.sv
// tb_rs_latch_ctrl: directed scoreboard checks plus a random
// bounce sweep with running s/r invariant and pulse-shape checks.
`timescale 1ns/1ps
module tb_rs_latch_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_set = 1'b0;
  logic btn_rst = 1'b0;
  logic s, r, busy, q_exp, conflict;

  rs_latch_ctrl #(
    .DEB_CYC(4),
    .PULSE_W(3),
    .GAP_W(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_set(btn_set),
    .btn_rst(btn_rst),
    .s(s),
    .r(r),
    .busy(busy),
    .q_exp(q_exp),
    .conflict(conflict)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    int         c;
    logic [4:0] v;
    string      tag;
  } exp_t;
  exp_t sb[$];

  task automatic check(string tag, logic [31:0] got, logic [31:0] want);
    total_cnt++;
    assert (got === want) pass_cnt++;
    else $error("FAIL %s: got %0b want %0b", tag, got, want);
  endtask

  function automatic logic [4:0] obs();
    return {s, r, busy, q_exp, conflict};
  endfunction

  task automatic push(int c, logic [4:0] v, string tag);
    exp_t e;
    e.c = c;
    e.v = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard consumer: compare entries due this cycle.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() != 0 && sb[0].c == cyc) begin
      e = sb.pop_front();
      check(e.tag, 32'(obs()), 32'(e.v));
    end
  end

  // Running invariant, pulse width and gap checks.
  int low_run = 0;
  int hi_run = 100;
  logic prev_p = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      low_run = 0;
      hi_run = 100;
      prev_p = 1'b0;
    end else begin
      check("sr_both_low", 32'(!s && !r), 32'd0);
      if (!s || !r) begin
        if (!prev_p) begin
          check("gap_before", 32'(hi_run >= 1), 32'd1);
          low_run = 0;
        end
        low_run++;
        hi_run = 0;
        prev_p = 1'b1;
      end else begin
        if (prev_p) check("pulse_width", 32'(low_run), 32'd3);
        if (hi_run < 100) hi_run++;
        prev_p = 1'b0;
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int seg_s;
    int seg_r;
    logic sv, rv, bv, qv;

    rst_n = 1'b0;
    tick(3);
    check("reset", 32'(obs()), 32'(5'b11000));
    rst_n = 1'b1;
    tick(3);
    check("idle", 32'(obs()), 32'(5'b11000));

    // Clean set press.
    e0 = cyc;
    btn_set = 1'b1;
    for (int n = 0; n < 15; n++) begin
      sv = !(n >= 7 && n <= 9);
      bv = (n >= 7 && n <= 10);
      qv = (n >= 10);
      push(e0 + 1 + n, {sv, 1'b1, bv, qv, 1'b0}, "clean_set");
    end
    tick(16);
    e0 = cyc;
    btn_set = 1'b0;
    for (int n = 0; n < 12; n++)
      push(e0 + 1 + n, 5'b11010, "set_release");
    tick(13);

    // Bounce shorter than the debounce window.
    e0 = cyc;
    for (int n = 0; n < 24; n++)
      push(e0 + 1 + n, 5'b11010, "bounce");
    btn_set = 1'b1;
    tick(2);
    btn_set = 1'b0;
    tick(2);
    btn_set = 1'b1;
    tick(2);
    btn_set = 1'b0;
    tick(20);

    // Simultaneous press.
    e0 = cyc;
    btn_set = 1'b1;
    btn_rst = 1'b1;
    for (int n = 0; n < 15; n++)
      push(e0 + 1 + n, {4'b1101, 1'(n == 6)}, "simul");
    tick(16);
    e0 = cyc;
    btn_set = 1'b0;
    btn_rst = 1'b0;
    for (int n = 0; n < 12; n++)
      push(e0 + 1 + n, 5'b11010, "simul_rel");
    tick(13);

    // Reset during the second low cycle of s.
    e0 = cyc;
    btn_set = 1'b1;
    for (int n = 0; n < 9; n++) begin
      sv = !(n >= 7);
      bv = (n >= 7);
      push(e0 + 1 + n, {sv, 1'b1, bv, 1'b1, 1'b0}, "pre_reset");
    end
    tick(9);
    #2;
    rst_n = 1'b0;
    btn_set = 1'b0;
    #1;
    check("async_reset", 32'(obs()), 32'(5'b11000));
    tick(2);
    rst_n = 1'b1;
    e0 = cyc;
    for (int n = 0; n < 15; n++)
      push(e0 + 1 + n, 5'b11000, "post_reset");
    tick(16);

    // Reset request queued behind a set pulse.
    e0 = cyc;
    btn_set = 1'b1;
    for (int n = 0; n < 21; n++) begin
      sv = !(n >= 7 && n <= 9);
      rv = !(n >= 12 && n <= 14);
      bv = (n >= 7 && n <= 10) || (n >= 12 && n <= 15);
      qv = (n >= 10 && n < 15);
      push(e0 + 1 + n, {sv, rv, bv, qv, 1'b0}, "queued");
    end
    tick(2);
    btn_rst = 1'b1;
    tick(20);
    e0 = cyc;
    btn_set = 1'b0;
    btn_rst = 1'b0;
    for (int n = 0; n < 12; n++)
      push(e0 + 1 + n, 5'b11000, "queued_rel");
    tick(13);

    // Random bouncing buttons.
    seg_s = 0;
    seg_r = 0;
    for (int i = 0; i < 10000; i++) begin
      if (seg_s == 0) begin
        btn_set = 1'($urandom_range(0, 1));
        seg_s = $urandom_range(1, 12);
      end else if ($urandom_range(0, 7) == 0) begin
        btn_set = ~btn_set;
      end
      if (seg_r == 0) begin
        btn_rst = 1'($urandom_range(0, 1));
        seg_r = $urandom_range(1, 12);
      end else if ($urandom_range(0, 7) == 0) begin
        btn_rst = ~btn_rst;
      end
      seg_s--;
      seg_r--;
      tick(1);
    end
    btn_set = 1'b0;
    btn_rst = 1'b0;
    tick(40);
    check("settled_busy", 32'(busy), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
